// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier
//   Sequential unsigned N x N multiplier. The product is formed MSB-first:
//   each RUN cycle shifts one multiplier bit out of BQ and adds the
//   multiplicand into a left-shifting accumulator. A result takes N RUN
//   cycles and is then presented for one FIN cycle.
// Ports
//   i_clk    clock, rising edge
//   i_rst    synchronous reset, active high
//   i_start  request a multiply (accepted in IDLE or FIN only)
//   i_a      multiplicand, captured on accept
//   i_b      multiplier, captured on accept
//   o_p      product register, held until the next product completes
//   o_busy   high while in RUN
//   o_done   one-cycle pulse when o_p first shows a new product
module shift_add_multiplier #(
  parameter int N = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic [2*N-1:0] o_p,
  output logic           o_busy,
  output logic           o_done
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t           r_state, w_state_nxt;
  logic [N-1:0]     r_mc, r_bq;
  logic [2*N-1:0]   r_acc, r_p, w_acc_nxt;
  logic [CW-1:0]    r_cnt;
  logic             w_accept, w_last;

  // START is only looked at outside RUN, so a request can never disturb
  // an operation in progress.
  always_comb begin
    w_accept  = (r_state != S_RUN) && i_start;
    w_last    = (r_state == S_RUN) && (r_cnt == CW'(1));
    w_acc_nxt = {r_acc[2*N-2:0], 1'b0} + (r_bq[N-1] ? {{N{1'b0}}, r_mc} : {(2*N){1'b0}});
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)  w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = i_start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mc  <= '0;
      r_bq  <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_p   <= '0;
    end else if (w_accept) begin
      // P is deliberately left alone: the old product stays visible
      // until the new final iteration overwrites it.
      r_mc  <= i_a;
      r_bq  <= i_b;
      r_acc <= '0;
      r_cnt <= CW'(N);
    end else if (r_state == S_RUN) begin
      r_acc <= w_acc_nxt;
      r_bq  <= {r_bq[N-2:0], 1'b0};
      r_cnt <= r_cnt - CW'(1);
      if (w_last) r_p <= w_acc_nxt;
    end
  end

  assign o_p    = r_p;
  assign o_busy = (r_state == S_RUN);
  assign o_done = (r_state == S_FIN);

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start8 = 1'b0, start4 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [15:0] p8;
  logic [7:0]  p4;
  logic        busy8, done8, busy4, done4;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  shift_add_multiplier #(.N(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start8), .i_a(a8), .i_b(b8),
    .o_p(p8), .o_busy(busy8), .o_done(done8)
  );

  shift_add_multiplier #(.N(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start4), .i_a(a4), .i_b(b4),
    .o_p(p4), .o_busy(busy4), .o_done(done4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a request accepted while not running yields a*b
  // exactly N edges later, shown for one cycle; reset clears everything.
  int          nn[2]     = '{8, 4};
  bit          m_run[2]  = '{0, 0};
  bit          m_done[2] = '{0, 0};
  int          m_k[2]    = '{0, 0};
  int unsigned m_prod[2] = '{0, 0};
  int unsigned m_p[2]    = '{0, 0};

  initial begin
    bit          crst;
    bit          cs[2];
    int unsigned ca[2], cb[2];
    forever begin
      @(posedge clk);
      crst = rst;
      cs[0] = start8; ca[0] = a8; cb[0] = b8;
      cs[1] = start4; ca[1] = a4; cb[1] = b4;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (crst) begin
          m_run[i] = 0; m_done[i] = 0; m_p[i] = 0;
        end else begin
          m_done[i] = 0;
          if (m_run[i]) begin
            m_k[i]++;
            if (m_k[i] == nn[i]) begin
              m_run[i] = 0; m_done[i] = 1; m_p[i] = m_prod[i];
            end
          end else if (cs[i]) begin
            m_run[i] = 1; m_k[i] = 0; m_prod[i] = ca[i] * cb[i];
          end
        end
      end
      if (chk_en) begin
        chk("busy8", busy8, m_run[0]);
        chk("done8", done8, m_done[0]);
        chk("p8",    p8,    m_p[0]);
        chk("busy4", busy4, m_run[1]);
        chk("done4", done4, m_done[1]);
        chk("p4",    p4,    m_p[1]);
      end
    end
  end

  function automatic logic cur_done(input int sel);
    return (sel == 0) ? done8 : done4;
  endfunction

  function automatic logic [31:0] cur_p(input int sel);
    return (sel == 0) ? 32'(p8) : 32'(p4);
  endfunction

  // Counts negedges after the accepting edge until DONE is seen (bounded).
  // With drop set, START is released and the operands are scrambled every
  // cycle to show they have no effect on the running multiply.
  task automatic wait_done(input int sel, input bit drop, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (drop) begin
        if (sel == 0) begin start8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); end
        else          begin start4 = 0; a4 = 4'($urandom); b4 = 4'($urandom); end
      end
    end while (!cur_done(sel) && n < 40);
    if (n >= 40) chk("done_timeout", 32'(n), 32'(nn[sel] + 1));
  endtask

  task automatic op(input int sel, input int unsigned a, input int unsigned b);
    int n;
    @(negedge clk);
    if (sel == 0) begin a8 = 8'(a); b8 = 8'(b); start8 = 1; end
    else          begin a4 = 4'(a); b4 = 4'(b); start4 = 1; end
    wait_done(sel, 1'b1, n);
    chk("latency", 32'(n), 32'(nn[sel] + 1));
    chk("prod",    cur_p(sel), a * b);
  endtask

  initial begin
    int n;
    bit seen;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_p", p8, 0); chk("rst_busy", busy8, 0); chk("rst_done", done8, 0);
    chk_en = 1;

    // Directed products, checked against hand-computed literals too
    op(0, 13, 11);   chk("p_13x11", p8, 32'h008F);
    repeat (3) @(negedge clk);
    chk("p_held", p8, 32'h008F);
    op(0, 255, 255); chk("p_255x255", p8, 32'hFE01);
    op(0, 0, 200);   chk("p_0x200", p8, 32'h0000);
    op(0, 1, 200);   chk("p_1x200", p8, 32'h00C8);

    // START pulsed mid-RUN must be ignored
    @(negedge clk); a8 = 100; b8 = 3; start8 = 1;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk); n++;
      if (n == 3) begin start8 = 1; a8 = 2; b8 = 2; end
      else start8 = 0;
      seen = done8;
    end
    chk("mid_lat", 32'(n), 9);
    chk("mid_p", p8, 300);

    // START held across two operations
    @(negedge clk); a8 = 3; b8 = 5; start8 = 1;
    @(negedge clk); a8 = 7; b8 = 9;
    wait_done(0, 1'b0, n);
    chk("b2b_lat1", 32'(n), 8);
    chk("b2b_p1", p8, 15);
    @(negedge clk); start8 = 0;
    chk("b2b_hold", p8, 15);
    wait_done(0, 1'b0, n);
    chk("b2b_gap", 32'(n + 1), 9);
    chk("b2b_p2", p8, 63);

    // Reset during the 4th RUN cycle aborts the multiply
    @(negedge clk); a8 = 50; b8 = 50; start8 = 1;
    @(negedge clk); start8 = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk); rst = 0;
    chk("abort_busy", busy8, 0); chk("abort_done", done8, 0); chk("abort_p", p8, 0);
    seen = 0;
    repeat (12) begin @(negedge clk); seen |= done8; end
    chk("abort_nodone", seen, 0);
    op(0, 6, 7); chk("p_6x7", p8, 42);

    // Random sweep, N=8
    for (int i = 0; i < 2000; i++) begin
      op(0, $urandom_range(0, 255), $urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Exhaustive, N=4
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) op(1, a, b);
    chk("p4_15x15", p4, 225);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
